// File: rtl/bram_frame_seq_pkg.sv
// Shared constants and state encoding for the line-buffer BRAM sequencer.
package bram_frame_seq_pkg;
    localparam int DEF_WR_AW      = 11;
    localparam int DEF_RD_AW      = 9;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        FILL  = S_FILL,
        DRAIN = S_DRAIN,
        FLUSH = S_FLUSH,
        DONE  = S_DONE
    } state_t;
endpackage

// File: rtl/bram_frame_seq_line_phase_cnt.sv
// Modulo-LINE_WORDS read counter; wrap strobes on the last word of each line.
module line_phase_cnt
    import bram_frame_seq_pkg::*;
#(
    parameter int LINE_WORDS = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic adv,
    output logic wrap
);
    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    logic [CW-1:0] cnt;

    assign wrap = adv && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (adv)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/bram_frame_seq.sv
// Fill/drain sequencer for the pixel line-buffer BRAM: byte writes on port A,
// word reads on port B, window-mux phase and a completion pulse.
module bram_frame_seq
    import bram_frame_seq_pkg::*;
#(
    parameter int WR_AW       = DEF_WR_AW,
    parameter int RD_AW       = DEF_RD_AW,
    parameter int FRAME_BYTES = 2048,
    parameter int LINE_WORDS  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             stall,
    output logic             ena,
    output logic             wea,
    output logic [WR_AW-1:0] addra,
    output logic             enb,
    output logic [RD_AW-1:0] addrb,
    output logic [2:0]       sel,
    output logic             rd_valid,
    output logic             rd_last,
    output logic             busy,
    output logic             complete
);
    localparam int FRAME_WORDS = FRAME_BYTES / BYTES_PER_WORD;
    localparam logic [WR_AW:0] WR_LAST = (WR_AW+1)'(FRAME_BYTES - 1);
    localparam logic [RD_AW:0] RD_LAST = (RD_AW+1)'(FRAME_WORDS - 1);

    state_t         state, state_nx;
    logic [WR_AW:0] wr_cnt;
    logic [RD_AW:0] rd_cnt;
    logic           wr_term, rd_term, clr_cnt, line_wrap;
    logic           rd_vld_q, rd_last_q;

    assign wr_term = (wr_cnt == WR_LAST);
    assign rd_term = (rd_cnt == RD_LAST);

    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        ena       = 1'b0;
        wea       = 1'b0;
        enb       = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = 1'b1;
                if (start) state_nx = FILL;
            end
            FILL: begin
                pix_ready = 1'b1;
                ena       = pix_valid;
                wea       = pix_valid;
                if (pix_valid && wr_term) state_nx = DRAIN;
            end
            DRAIN: begin
                enb = ~stall;
                if (!stall && rd_term) state_nx = FLUSH;
            end
            FLUSH: state_nx = DONE;
            DONE: begin
                // Clear here so the next sequence sees zeroed addresses in IDLE.
                clr_cnt  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            sel       <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state     <= state_nx;
            rd_vld_q  <= enb;
            rd_last_q <= enb && rd_term;
            if (clr_cnt) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                sel    <= '0;
            end else begin
                // Terminal addresses hold instead of rolling past the segment.
                if (wea && !wr_term) wr_cnt <= wr_cnt + 1'b1;
                if (enb && !rd_term) rd_cnt <= rd_cnt + 1'b1;
                if (line_wrap)       sel    <= sel + 3'd1;
            end
        end
    end

    line_phase_cnt #(.LINE_WORDS(LINE_WORDS)) u_phase (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .adv   (enb),
        .wrap  (line_wrap)
    );

    assign addra    = wr_cnt[WR_AW-1:0];
    assign addrb    = rd_cnt[RD_AW-1:0];
    assign rd_valid = rd_vld_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state != IDLE);
    assign complete = (state == DONE);
endmodule

// File: tb/tb_bram_frame_seq.sv
// Randomized bench: per-cycle stimulus is pre-generated, expected write/read
// schedules are derived from it, then both DUTs are compared cycle by cycle.
module tb_bram_frame_seq;
    localparam int FB   = 16;
    localparam int FW   = FB / 4;
    localparam int MAXC = 200;

    logic        clk, reset, start, pix_valid, stall;
    logic        pix_ready, ena, wea, enb, rd_valid, rd_last, busy, complete;
    logic [10:0] addra;
    logic [8:0]  addrb;
    logic [2:0]  sel;
    logic        pix_ready1, ena1, wea1, enb1, rd_valid1, rd_last1, busy1, complete1;
    logic [10:0] addra1;
    logic [8:0]  addrb1;
    logic [2:0]  sel1;

    bram_frame_seq #(.FRAME_BYTES(FB), .LINE_WORDS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .stall(stall), .ena(ena), .wea(wea),
        .addra(addra), .enb(enb), .addrb(addrb), .sel(sel),
        .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .complete(complete)
    );

    bram_frame_seq #(.FRAME_BYTES(FB), .LINE_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready1), .stall(stall), .ena(ena1), .wea(wea1),
        .addra(addra1), .enb(enb1), .addrb(addrb1), .sel(sel1),
        .rd_valid(rd_valid1), .rd_last(rd_last1), .busy(busy1), .complete(complete1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cur_c = 0;
    bit pv_s[MAXC], st_s[MAXC], go_s[MAXC];
    int w_idx[MAXC], r_idx[MAXC];
    int wl, rl;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_c, got, exp);
    endtask

    // mode 0: steady input, 1: gapped input, 2: 3-cycle stall after 2nd read, 3: random
    task automatic gen(input int mode, input bit poke);
        int nw, nr;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       begin pv_s[c] = 1'b1;   st_s[c] = 1'b0; end
                1:       begin pv_s[c] = c[0];   st_s[c] = 1'b0; end
                2:       begin pv_s[c] = 1'b1;   st_s[c] = (c >= 19 && c <= 21); end
                default: begin
                    pv_s[c] = (c > 100) || ($urandom_range(0, 2) != 0);
                    st_s[c] = (c < 150) && ($urandom_range(0, 2) == 0);
                end
            endcase
            go_s[c]  = (c == 0);
            w_idx[c] = -1;
            r_idx[c] = -1;
        end
        nw = 0; nr = 0; wl = -1; rl = -1;
        for (int c = 1; c < MAXC; c++) begin
            if (nw < FB && pv_s[c]) begin
                w_idx[c] = nw++;
                if (nw == FB) wl = c;
            end else if (nw == FB && nr < FW && !st_s[c]) begin
                r_idx[c] = nr++;
                if (nr == FW) rl = c;
            end
        end
        if (poke)
            for (int c = 1; c <= rl + 2; c++)
                go_s[c] = ($urandom_range(0, 1) == 1) || (c == 2) || (c == rl + 2);
    endtask

    task automatic run_frame(input int abort_c);
        for (int c = 0; c <= rl + 4; c++) begin
            start = go_s[c]; pix_valid = pv_s[c]; stall = st_s[c]; cur_c = c;
            if (c == abort_c) begin
                chk("pre_addrb", int'(addrb), 2);
                #2 reset = 1'b1;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_enb", int'(enb), 0);
                chk("rst_addrb", int'(addrb), 0);
                chk("rst_sel", int'(sel), 0);
                chk("rst_rdv", int'(rd_valid), 0);
                chk("rst_cmp", int'(complete), 0);
                start = 1'b0; pix_valid = 1'b0; stall = 1'b0;
                @(posedge clk); #1 reset = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("ab_busy", int'(busy), 0);
                    chk("ab_cmp", int'(complete), 0);
                    chk("ab_addra", int'(addra), 0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(negedge clk);
            chk("wea", int'(wea), int'(w_idx[c] >= 0));
            chk("ena", int'(ena), int'(w_idx[c] >= 0));
            chk("pix_ready", int'(pix_ready), int'(c >= 1 && c <= wl));
            chk("enb", int'(enb), int'(r_idx[c] >= 0));
            chk("rd_valid", int'(rd_valid), int'(c > 0 && r_idx[c-1] >= 0));
            chk("rd_last", int'(rd_last), int'(c > 0 && r_idx[c-1] == FW - 1));
            chk("complete", int'(complete), int'(c == rl + 2));
            chk("busy", int'(busy), int'(c >= 1 && c <= rl + 2));
            chk("complete1", int'(complete1), int'(c == rl + 2));
            if (w_idx[c] >= 0) chk("addra", int'(addra), w_idx[c]);
            if (r_idx[c] >= 0) begin
                chk("addrb", int'(addrb), r_idx[c]);
                chk("sel", int'(sel), (r_idx[c] / 2) % 8);
                chk("sel_lw1", int'(sel1), r_idx[c] % 8);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addra", int'(addra), 0);
        chk("reset_addrb", int'(addrb), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rdv", int'(rd_valid), 0);
        chk("reset_ready", int'(pix_ready), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        gen(0, 1'b0); run_frame(-1);
        gen(1, 1'b0); run_frame(-1);
        gen(2, 1'b0); run_frame(-1);
        gen(0, 1'b0); run_frame(wl + 3);
        gen(0, 1'b1); run_frame(-1);
        for (int i = 0; i < 6; i++) begin
            gen(3, i[0]); run_frame(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
